datapath_sequencer: RTL and testbench
=====================================

Name: datapath_sequencer

Overview:
Multi-cycle controller that sequences the 32x64 register file, the ALU and the 256x64 RAM datapath. It accepts one 32-bit instruction at a time over a valid/ready handshake and decodes it. It then drives the datapath strobes (read/write selects, ALU function, carry, RAM write, writeback mux) over 1–2 execute cycles. It sits between the instruction source (testbench or future fetch unit) and the datapath top level.

Parameters:
INSTR_W, 32, instruction word width
REG_AW, 5, register-file address width
FUNC_W, 5, ALU function-select width
FLAG_W, 4, ALU status-bit width
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset; synchronous, active-low
instr  in  INSTR_W  instruction word
instr_valid  in  1  instruction presented
instr_ready  out  1  sequencer can accept an instruction
readA  out  REG_AW  register-file port A select
readB  out  REG_AW  register-file port B select
writeReg  out  REG_AW  register-file write select
write  out  1  register-file write enable
functionsel  out  FUNC_W  ALU function select
ALUcarry  out  1  ALU carry-in
RAMwrite  out  1  RAM write enable (address = ALU result[7:0], data = port B)
muxSelect  out  1  writeback source: 0 = ALU result, 1 = RAM read data
signalBits  in  FLAG_W  ALU status bits
flags  out  FLAG_W  status captured on last ALU instruction
busy  out  1  instruction in flight
done  out  1  one-cycle pulse per retired instruction
retired  out  CNT_W  retired-instruction count

Behaviour:
- Instruction fields: [31:30] op (00 NOP, 01 ALU, 10 LOAD, 11 STORE); [29:25] func; [24:20] rd; [19:15] ra; [14:10] rb; [9] carry; [8:0] reserved, ignored.
- States: IDLE, EXEC, MEM.
- IDLE: instr_ready=1. On instr_valid, latch instr into instr_q and go to EXEC. No other transition.
- EXEC: readA=ra, readB=rb, functionsel=func, ALUcarry=carry.
  - ALU: write=1, writeReg=rd, muxSelect=0; flags<=signalBits at the end of the cycle; go to IDLE.
  - STORE: RAMwrite=1; go to IDLE.
  - LOAD: no strobes; go to MEM (RAM read is registered, so data is valid the next cycle).
  - NOP: no strobes; go to IDLE.
- MEM (LOAD only): readA/readB/functionsel/ALUcarry held as in EXEC so the address stays stable; write=1, writeReg=rd, muxSelect=1; go to IDLE.
- Output timing:
  - All outputs decode only from state/instr_q/registered counters; there is no combinational path from instr/instr_valid/signalBits to any output.
  - Outside active phases, select outputs are 0.
  - write and RAMwrite are never both 1.
- done:
  - Registered; 1 for exactly the cycle after the final execute cycle (first IDLE cycle), coincident with instr_ready=1.
  - retired increments by 1 in that same edge and wraps modulo 2^CNT_W.
- busy=1 in EXEC and MEM.
- Latency (accept edge = cycle 0): NOP/ALU/STORE: EXEC in cycle 1, done in cycle 2. LOAD: EXEC cycle 1, MEM cycle 2, done cycle 3. Back-to-back issue: the next instruction is accepted in the done cycle.
- instr_valid is ignored while not in IDLE; no instruction is lost because instr_ready=0 there.
- Reset (rst=0 at a rising edge), including mid-instruction:
  - state<=IDLE; instr_q, flags, retired, done <= 0.
  - The in-flight instruction is abandoned, with no done and no count.
  - While rst=0, instr_ready=0 and all strobes=0.
  - First accept is possible in the first cycle after rst returns to 1.
- rd=0 is an ordinary register; no special casing.

Decomposition:
- Package datapath_ctrl_pkg:
  - opcode constants OP_NOP/OP_ALU/OP_LOAD/OP_STORE.
  - state encoding ST_IDLE/ST_EXEC/ST_MEM.
  - field bit positions (OP_HI/LO, FUNC_HI/LO, RD/RA/RB ranges, CARRY_BIT).
  - writeback mux constants WB_ALU=0, WB_RAM=1.
- One natural sub-module, instr_field_decode: purely combinational; splits instr_q into op/func/rd/ra/rb/carry. The FSM, strobes and counters stay in datapath_sequencer.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with instr_valid=1 -> instr_ready=0, all strobes 0, flags=0, retired=0. Release -> instr_ready=1 next cycle.
2. ALU: op=01, func=5'h03, rd=7, ra=1, rb=2, carry=1, signalBits=4'b1010 -> next cycle readA=1, readB=2, functionsel=3, ALUcarry=1, write=1, writeReg=7, muxSelect=0. Following cycle done=1, flags=4'b1010, retired=1.
3. STORE then LOAD: STORE ra=3, rb=4 -> one cycle RAMwrite=1, write=0. Then LOAD rd=9, ra=3 -> EXEC with no strobes, then MEM with write=1, writeReg=9, muxSelect=1, readA=3. done arrives 3 cycles after accept.
4. Back-to-back: instr_valid held high with 4 NOPs -> accepts every 2 cycles, 4 done pulses, retired=4, busy alternating.
5. Reset mid-LOAD: assert rst=0 during MEM -> next cycle state IDLE, write=0, no done, retired unchanged at 0.
6. Counter wrap: CNT_W=4, issue 17 NOPs -> retired goes 15->0->1. Reserved bits set to 9'h1FF have no effect.

Source files
------------

// File: rtl/datapath_ctrl_pkg.sv
// Shared constants and types for the datapath sequencer: opcodes, states, field positions.
package datapath_ctrl_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned OP_WIDTH    = 2;
  localparam int unsigned FUNC_WIDTH  = 5;
  localparam int unsigned REG_WIDTH   = 5;

  // Instruction field bit positions
  localparam int unsigned OP_HI     = 31;
  localparam int unsigned OP_LO     = 30;
  localparam int unsigned FUNC_HI   = 29;
  localparam int unsigned FUNC_LO   = 25;
  localparam int unsigned RD_HI     = 24;
  localparam int unsigned RD_LO     = 20;
  localparam int unsigned RA_HI     = 19;
  localparam int unsigned RA_LO     = 15;
  localparam int unsigned RB_HI     = 14;
  localparam int unsigned RB_LO     = 10;
  localparam int unsigned CARRY_BIT = 9;
  localparam int unsigned RSV_HI    = 8;
  localparam int unsigned RSV_LO    = 0;

  // Opcodes
  localparam logic [OP_WIDTH-1:0] OP_NOP   = 2'b00;
  localparam logic [OP_WIDTH-1:0] OP_ALU   = 2'b01;
  localparam logic [OP_WIDTH-1:0] OP_LOAD  = 2'b10;
  localparam logic [OP_WIDTH-1:0] OP_STORE = 2'b11;

  // Writeback mux sources
  localparam logic WB_ALU = 1'b0;
  localparam logic WB_RAM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_WIDTH-1:0]   op;
    logic [FUNC_WIDTH-1:0] func;
    logic [REG_WIDTH-1:0]  rd;
    logic [REG_WIDTH-1:0]  ra;
    logic [REG_WIDTH-1:0]  rb;
    logic                  carry;
  } instr_fields_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational split of a latched instruction word into its fields.
module instr_field_decode
  import datapath_ctrl_pkg::*;
(
  input  logic [INSTR_WIDTH-1:0] instr,
  output instr_fields_t          fields
);

  // Reserved bits carry no meaning
  logic unused_rsv;
  assign unused_rsv = ^instr[RSV_HI:RSV_LO];

  // Field extraction
  always_comb begin
    fields       = '0;
    fields.op    = instr[OP_HI:OP_LO];
    fields.func  = instr[FUNC_HI:FUNC_LO];
    fields.rd    = instr[RD_HI:RD_LO];
    fields.ra    = instr[RA_HI:RA_LO];
    fields.rb    = instr[RB_HI:RB_LO];
    fields.carry = instr[CARRY_BIT];
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle controller: accepts one instruction, then drives register file/ALU/RAM strobes.
module datapath_sequencer
  import datapath_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned FUNC_W  = 5,
  parameter int unsigned FLAG_W  = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [REG_AW-1:0]  readA,
  output logic [REG_AW-1:0]  readB,
  output logic [REG_AW-1:0]  writeReg,
  output logic               write,
  output logic [FUNC_W-1:0]  functionsel,
  output logic               ALUcarry,
  output logic               RAMwrite,
  output logic               muxSelect,
  input  logic [FLAG_W-1:0]  signalBits,
  output logic [FLAG_W-1:0]  flags,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   retired
);

  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                done_q, done_d;
  instr_fields_t       f;

  instr_field_decode u_decode (
    .instr  (instr_q),
    .fields (f)
  );

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      flags_q   <= '0;
      retired_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      flags_q   <= flags_d;
      retired_q <= retired_d;
      done_q    <= done_d;
    end
  end

  // Next-state, flag capture and retirement bookkeeping
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    flags_d   = flags_q;
    retired_d = retired_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (f.op == OP_LOAD) begin
          state_d = ST_MEM;
        end else begin
          if (f.op == OP_ALU) flags_d = signalBits;
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          retired_d = retired_q + CNT_W'(1);
        end
      end
      ST_MEM: begin
        state_d   = ST_IDLE;
        done_d    = 1'b1;
        retired_d = retired_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe decode from state and latched instruction; forced quiet while reset is asserted
  always_comb begin
    instr_ready = 1'b0;
    readA       = '0;
    readB       = '0;
    writeReg    = '0;
    write       = 1'b0;
    functionsel = '0;
    ALUcarry    = 1'b0;
    RAMwrite    = 1'b0;
    muxSelect   = WB_ALU;
    if (rst) begin
      unique case (state_q)
        ST_IDLE: instr_ready = 1'b1;
        ST_EXEC: begin
          readA       = REG_AW'(f.ra);
          readB       = REG_AW'(f.rb);
          functionsel = FUNC_W'(f.func);
          ALUcarry    = f.carry;
          if (f.op == OP_ALU) begin
            write     = 1'b1;
            writeReg  = REG_AW'(f.rd);
            muxSelect = WB_ALU;
          end else if (f.op == OP_STORE) begin
            RAMwrite  = 1'b1;
          end
        end
        ST_MEM: begin
          readA       = REG_AW'(f.ra);
          readB       = REG_AW'(f.rb);
          functionsel = FUNC_W'(f.func);
          ALUcarry    = f.carry;
          write       = 1'b1;
          writeReg    = REG_AW'(f.rd);
          muxSelect   = WB_RAM;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign flags   = flags_q;
  assign done    = done_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed, table-driven bench for datapath_sequencer (counter narrowed to 4 bits).
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  readA, readB, writeReg;
  logic        write;
  logic [4:0]  functionsel;
  logic        ALUcarry, RAMwrite, muxSelect;
  logic [3:0]  signalBits, flags;
  logic        busy, done;
  logic [3:0]  retired;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  datapath_sequencer #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .readA(readA), .readB(readB), .writeReg(writeReg),
    .write(write), .functionsel(functionsel), .ALUcarry(ALUcarry), .RAMwrite(RAMwrite),
    .muxSelect(muxSelect), .signalBits(signalBits), .flags(flags), .busy(busy),
    .done(done), .retired(retired)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [3:0]  sig;
    logic        is_load;
    logic [26:0] exp_exec;
    logic [26:0] exp_mem;
    logic [3:0]  exp_flags;
  } vec_t;

  function automatic logic [31:0] mk(input logic [1:0] op, input logic [4:0] fn,
                                     input logic [4:0] rd, input logic [4:0] ra,
                                     input logic [4:0] rb, input logic c, input logic [8:0] rsv);
    return {op, fn, rd, ra, rb, c, rsv};
  endfunction

  // {readA, readB, functionsel, ALUcarry, write, writeReg, RAMwrite, muxSelect, busy, instr_ready, done}
  function automatic logic [26:0] bun(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] fn,
                                      input logic c, input logic w, input logic [4:0] wr,
                                      input logic rw, input logic mx, input logic bsy,
                                      input logic rdy, input logic dn);
    return {ra, rb, fn, c, w, wr, rw, mx, bsy, rdy, dn};
  endfunction

  function automatic logic [26:0] obs();
    return {readA, readB, functionsel, ALUcarry, write, writeReg, RAMwrite, muxSelect,
            busy, instr_ready, done};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Issue one instruction from IDLE and check every cycle through its done pulse
  task automatic run(input vec_t v);
    chk({v.name, " ready"}, 32'(instr_ready), 32'd1);
    instr       = v.instr;
    instr_valid = 1'b1;
    signalBits  = v.sig;
    @(negedge clk);
    instr_valid = 1'b0;
    chk({v.name, " exec"}, 32'(obs()), 32'(v.exp_exec));
    if (v.is_load) begin
      @(negedge clk);
      chk({v.name, " mem"}, 32'(obs()), 32'(v.exp_mem));
    end
    @(negedge clk);
    exp_ret = (exp_ret + 1) % 16;
    chk({v.name, " done"}, 32'({done, busy, instr_ready, write, RAMwrite}), 32'(5'b10100));
    chk({v.name, " retired"}, 32'(retired), 32'(exp_ret));
    chk({v.name, " flags"}, 32'(flags), 32'(v.exp_flags));
  endtask

  vec_t vecs[6];
  vec_t v;

  initial begin
    rst         = 1'b0;
    instr_valid = 1'b1;
    instr       = mk(2'b01, 5'h03, 5'd7, 5'd1, 5'd2, 1'b1, 9'h000);
    signalBits  = 4'b1111;

    vecs[0] = '{"alu", mk(2'b01, 5'h03, 5'd7, 5'd1, 5'd2, 1'b1, 9'h000), 4'b1010, 1'b0,
                bun(5'd1, 5'd2, 5'h03, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), '0, 4'b1010};
    vecs[1] = '{"store", mk(2'b11, 5'h02, 5'd0, 5'd3, 5'd4, 1'b0, 9'h000), 4'b0101, 1'b0,
                bun(5'd3, 5'd4, 5'h02, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), '0, 4'b1010};
    vecs[2] = '{"load", mk(2'b10, 5'h00, 5'd9, 5'd3, 5'd0, 1'b0, 9'h000), 4'b0110, 1'b1,
                bun(5'd3, 5'd0, 5'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
                bun(5'd3, 5'd0, 5'h00, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), 4'b1010};
    vecs[3] = '{"nop_rsv", mk(2'b00, 5'h1F, 5'd5, 5'd6, 5'd7, 1'b1, 9'h1FF), 4'b1111, 1'b0,
                bun(5'd6, 5'd7, 5'h1F, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), '0, 4'b1010};
    vecs[4] = '{"alu_rd0", mk(2'b01, 5'h11, 5'd0, 5'd31, 5'd30, 1'b0, 9'h1FF), 4'b0111, 1'b0,
                bun(5'd31, 5'd30, 5'h11, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), '0, 4'b0111};
    vecs[5] = '{"load_rsv", mk(2'b10, 5'h04, 5'd0, 5'd8, 5'd1, 1'b1, 9'h1FF), 4'b0001, 1'b1,
                bun(5'd8, 5'd1, 5'h04, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
                bun(5'd8, 5'd1, 5'h04, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), 4'b0111};

    // Reset held with a valid instruction presented
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst strobes", 32'(obs()), 32'(bun('0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
      chk("rst flags", 32'(flags), 32'd0);
      chk("rst retired", 32'(retired), 32'd0);
    end
    rst         = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("post-rst ready", 32'(instr_ready), 32'd1);

    // Table-driven single instructions
    for (int i = 0; i < 6; i++) run(vecs[i]);

    // Back-to-back NOPs with valid held high
    instr       = mk(2'b00, 5'h00, 5'd0, 5'd0, 5'd0, 1'b0, 9'h000);
    instr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i % 2 == 1) exp_ret = (exp_ret + 1) % 16;
      chk("b2b busy", 32'(busy), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("b2b done", 32'(done), (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i == 7) instr_valid = 1'b0;
    end
    chk("b2b retired", 32'(retired), 32'(exp_ret));

    // Reset during the MEM cycle of a LOAD
    chk("mid ready", 32'(instr_ready), 32'd1);
    instr       = mk(2'b10, 5'h00, 5'd9, 5'd3, 5'd0, 1'b0, 9'h000);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("mid mem write", 32'(write), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid rst gated", 32'({write, instr_ready, muxSelect}), 32'd0);
    @(negedge clk);
    exp_ret = 0;
    chk("mid after rst", 32'({busy, done, write, instr_ready}), 32'd0);
    chk("mid retired", 32'(retired), 32'(exp_ret));
    rst = 1'b1;
    #1;
    chk("mid release ready", 32'(instr_ready), 32'd1);
    @(negedge clk);
    chk("mid no done", 32'(done), 32'd0);
    chk("mid retired2", 32'(retired), 32'(exp_ret));

    // Counter wrap with reserved bits set
    for (int i = 0; i < 17; i++) begin
      v = '{"wrap_nop", mk(2'b00, 5'h00, 5'd0, 5'd0, 5'd0, 1'b0, 9'h1FF), 4'b1100, 1'b0,
            bun('0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), '0, 4'b0000};
      run(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
